// File: rtl/chat_buffer_if.sv
// rtl/chat_buffer_if.sv - push/pop byte handshake bundle for the chat buffer controller
interface chat_buffer_if #(
  parameter int DATA_W = 8
) ();
  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_data;
  logic              pop_ready;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );
endinterface

// File: rtl/chat_buffer_ctrl.sv
// rtl/chat_buffer_ctrl.sv - ring-buffer controller for the chat message RAM
// Pointers/occupancy plus a read sequencer that stages the oldest byte in a held output register.
module chat_buffer_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  chat_buffer_if.slave      bus,
  input  logic              flush_i,
  output logic [ADDR_W:0]   level_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [ADDR_W-1:0] ram_waddr_o,
  output logic [ADDR_W-1:0] ram_raddr_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] pop_data_q;
  logic              overflow_q;
  logic              issue, push_acc, full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (issue) state_d = S_WAIT;
        S_WAIT:  state_d = S_HOLD;
        S_HOLD:  if (bus.pop_ready) state_d = issue ? S_WAIT : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Issue only looks at the committed count, so a read never hits the slot being written now.
  always_comb begin
    issue = 1'b0;
    if (!flush_i && count_q != '0) begin
      case (state_q)
        S_IDLE:  issue = 1'b1;
        S_HOLD:  issue = bus.pop_ready;
        default: issue = 1'b0;
      endcase
    end
  end

  assign full           = (count_q == (ADDR_W+1)'(DEPTH));
  assign bus.push_ready = !full && !flush_i;
  assign push_acc       = bus.push_valid && bus.push_ready;
  assign bus.pop_valid  = (state_q == S_HOLD);
  assign bus.pop_data   = pop_data_q;
  assign count_d        = count_q + (ADDR_W+1)'(push_acc) - (ADDR_W+1)'(issue);

  assign ram_we_o    = push_acc;
  assign ram_wdata_o = bus.push_data;
  assign ram_waddr_o = wr_ptr_q;
  assign ram_raddr_o = rd_ptr_q;

  assign level_o    = count_q + (ADDR_W+1)'(state_q != S_IDLE);
  assign full_o     = full;
  assign empty_o    = (level_o == '0);
  assign overflow_o = overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pop_data_q <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue)    rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (state_q == S_WAIT) pop_data_q <= ram_rdata_i;
      if (bus.push_valid && full) overflow_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_chat_buffer_ctrl.sv
// tb/tb_chat_buffer_ctrl.sv - randomized scoreboard bench for chat_buffer_ctrl
module tb_chat_buffer_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [ADDR_W:0]   level;
  logic              full, empty, overflow, ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] mem [1024];

  always #5 clk = ~clk;

  chat_buffer_if #(.DATA_W(DATA_W)) bus ();

  chat_buffer_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush_i(flush),
    .level_o(level), .full_o(full), .empty_o(empty), .overflow_o(overflow),
    .ram_we_o(ram_we), .ram_wdata_o(ram_wdata), .ram_waddr_o(ram_waddr),
    .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_pop_cyc = -10;
  int pops = 0;
  logic [7:0] q[$];
  logic [7:0] held;
  logic       held_v = 1'b0;
  logic       s_pop_valid, s_push_ready, s_full, s_ovf, s_we;
  logic [7:0] s_pop_data;
  logic [ADDR_W:0]   s_level;
  logic [ADDR_W-1:0] s_waddr;

  // One clock of stimulus; the queue q is the reference contents, oldest first.
  task automatic step(input logic pv, input logic [7:0] pd, input logic pr, input logic fl,
                      output logic accepted);
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.pop_ready  = pr;
    flush          = fl;
    #1;
    s_pop_valid = bus.pop_valid; s_pop_data = bus.pop_data; s_push_ready = bus.push_ready;
    s_full = full; s_ovf = overflow; s_level = level; s_waddr = ram_waddr; s_we = ram_we;
    checks++;
    if (level !== (ADDR_W+1)'(q.size())) begin
      failures++; $display("FAIL level cyc=%0d got=%0d exp=%0d", cyc, level, q.size());
    end
    checks++;
    if (empty !== (q.size() == 0)) begin
      failures++; $display("FAIL empty cyc=%0d got=%0b exp=%0b", cyc, empty, q.size() == 0);
    end
    checks++;
    if (ram_we !== (pv && bus.push_ready)) begin
      failures++; $display("FAIL ram_we cyc=%0d got=%0b exp=%0b", cyc, ram_we, pv && bus.push_ready);
    end
    if (held_v) begin
      checks++;
      if (bus.pop_valid !== 1'b1 || bus.pop_data !== held) begin
        failures++;
        $display("FAIL pop_hold cyc=%0d got=%0b/%02h exp=1/%02h", cyc, bus.pop_valid, bus.pop_data, held);
      end
    end
    if (bus.pop_valid && pr) begin
      checks++;
      if (q.size() == 0) begin
        failures++; $display("FAIL pop_order cyc=%0d got=%02h exp=none", cyc, bus.pop_data);
      end else begin
        if (bus.pop_data !== q[0]) begin
          failures++; $display("FAIL pop_order cyc=%0d got=%02h exp=%02h", cyc, bus.pop_data, q[0]);
        end
        void'(q.pop_front());
      end
      checks++;
      if (cyc - last_pop_cyc < 2) begin
        failures++; $display("FAIL pop_rate cyc=%0d got_gap=%0d exp_min=2", cyc, cyc - last_pop_cyc);
      end
      last_pop_cyc = cyc;
      pops++;
    end
    held_v = bus.pop_valid && !pr;
    held   = bus.pop_data;
    accepted = pv && bus.push_ready;
    if (accepted) q.push_back(pd);
    if (fl) begin
      checks++;
      if (bus.push_ready !== 1'b0 || ram_we !== 1'b0) begin
        failures++; $display("FAIL flush_push cyc=%0d got_ready=%0b got_we=%0b exp=0/0", cyc, bus.push_ready, ram_we);
      end
      q.delete();
      held_v = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    logic a;
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, a);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++; $display("FAIL drain_timeout got_left=%0d exp=0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.push_valid = 1'b0; bus.push_data = '0; bus.pop_ready = 1'b0; flush = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (level !== 0 || empty !== 1'b1 || full !== 1'b0 || bus.push_ready !== 1'b1 ||
        bus.pop_valid !== 1'b0 || bus.pop_data !== 8'h00 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset got lvl=%0d e=%0b f=%0b pr=%0b pv=%0b pd=%02h ov=%0b exp 0/1/0/1/0/00/0",
               level, empty, full, bus.push_ready, bus.pop_valid, bus.pop_data, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic a;
    int first = -1;
    step(1'b1, 8'h41, 1'b1, 1'b0, a);
    checks++;
    if (s_we !== 1'b1 || s_waddr !== '0) begin
      failures++; $display("FAIL single_write got_we=%0b got_addr=%0d exp=1/0", s_we, s_waddr);
    end
    for (int c = 1; c < 10; c++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, a);
      if (s_pop_valid && first < 0) begin
        first = c;
        checks++;
        if (s_pop_data !== 8'h41) begin
          failures++; $display("FAIL single_data got=%02h exp=41", s_pop_data);
        end
      end
    end
    checks++;
    if (first != 3) begin
      failures++; $display("FAIL single_latency got=%0d exp=3", first);
    end
  endtask

  task automatic test_fill();
    logic a;
    int refused = 0;
    for (int i = 0; i < 1025; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, a);
      if (!a) refused++;
    end
    checks++;
    if (refused != 0) begin
      failures++; $display("FAIL fill_accept got_refused=%0d exp=0", refused);
    end
    step(1'b1, 8'hAA, 1'b0, 1'b0, a);
    checks++;
    if (a !== 1'b0 || s_full !== 1'b1 || s_level !== 1025) begin
      failures++; $display("FAIL fill_full got acc=%0b full=%0b lvl=%0d exp=0/1/1025", a, s_full, s_level);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, a);
    checks++;
    if (s_ovf !== 1'b1 || s_level !== 1025) begin
      failures++; $display("FAIL fill_overflow got ov=%0b lvl=%0d exp=1/1025", s_ovf, s_level);
    end
  endtask

  task automatic test_drain();
    logic a;
    int p0 = pops;
    drain(3000);
    checks++;
    if (pops - p0 != 1025) begin
      failures++; $display("FAIL drain_count got=%0d exp=1025", pops - p0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, a);
    checks++;
    if (s_ovf !== 1'b1) begin
      failures++; $display("FAIL drain_overflow got=%0b exp=1", s_ovf);
    end
  endtask

  task automatic test_wrap();
    logic a;
    int acc = 0;
    int p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0, a);
      if (a) acc++;
    end
    drain(2000);
    checks++;
    if (acc != 1500 || pops - p0 != 1500) begin
      failures++; $display("FAIL wrap got_acc=%0d got_pops=%0d exp=1500/1500", acc, pops - p0);
    end
  endtask

  task automatic test_stall();
    logic a;
    int acc = 0;
    int n = 0;
    logic [7:0] d0;
    logic [ADDR_W:0] l0;
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, a);
    while (!s_pop_valid && n < 10) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, a);
      n++;
    end
    checks++;
    if (!s_pop_valid) begin
      failures++; $display("FAIL stall_hold got_pop_valid=0 exp=1");
    end
    d0 = s_pop_data;
    l0 = s_level;
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom), 8'($urandom), 1'b0, 1'b0, a);
      if (a) acc++;
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, a);
    checks++;
    if (s_pop_data !== d0 || s_level !== l0 + (ADDR_W+1)'(acc)) begin
      failures++;
      $display("FAIL stall got data=%02h lvl=%0d exp=%02h/%0d", s_pop_data, s_level, d0, l0 + (ADDR_W+1)'(acc));
    end
    drain(200);
  endtask

  task automatic test_flush();
    logic a;
    step(1'b1, 8'($urandom), 1'b1, 1'b0, a);
    step(1'b0, 8'h00, 1'b1, 1'b0, a);
    checks++;
    if (s_ovf !== 1'b1) begin
      failures++; $display("FAIL flush_pre_overflow got=%0b exp=1", s_ovf);
    end
    step(1'b1, 8'h55, 1'b0, 1'b1, a);
    step(1'b0, 8'h00, 1'b1, 1'b0, a);
    checks++;
    if (s_level !== 0 || s_pop_valid !== 1'b0 || s_ovf !== 1'b0) begin
      failures++; $display("FAIL flush got lvl=%0d pv=%0b ov=%0b exp=0/0/0", s_level, s_pop_valid, s_ovf);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, a);
  endtask

  task automatic test_rst_mid_burst();
    logic a;
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, a);
    bus.push_valid = 1'b1; bus.pop_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (level !== 0 || empty !== 1'b1 || full !== 1'b0 || bus.pop_valid !== 1'b0 ||
        bus.pop_data !== 8'h00 || overflow !== 1'b0 || ram_waddr !== '0 || ram_raddr !== '0) begin
      failures++;
      $display("FAIL async_rst got lvl=%0d e=%0b f=%0b pv=%0b pd=%02h ov=%0b wa=%0d ra=%0d exp 0/1/0/0/00/0/0/0",
               level, empty, full, bus.pop_valid, bus.pop_data, overflow, ram_waddr, ram_raddr);
    end
    q.delete();
    held_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h7E, 1'b1, 1'b0, a);
    drain(20);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_wrap();
    test_stall();
    test_flush();
    test_rst_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
